bus_slave_port: RTL and testbench
=================================

# bus_slave_port

Serial bus responder sitting at the slave end of the two-master shared bus, one instance per slave behind the address decoder. It deserialises the request frame a master port shifts out (a read/write flag, a 12-bit local address and, for writes, 8 data bits), performs the access on a local synchronous memory, and for reads serialises the 8-bit result back toward the master. Frame length is fixed, so master ports can count cycles without a handshake beyond `bus_done`.

## Interface
- `ADDR_WIDTH`, 12, local address width; the top 2 bits of the 14-bit system address are stripped by the decoder.
- `DATA_WIDTH`, 8, data word width.
- `MEM_DEPTH`, 4096, memory words (2**ADDR_WIDTH).
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high.
- `bus_sel`  in  1  decoder select for this slave; must stay high for the whole frame.
- `bus_start`  in  1  one-cycle frame-start strobe.
- `bus_rw`  in  1  sampled with `bus_start`; 1 = read, 0 = write.
- `bus_mosi`  in  1  serial address/data from master, MSB first.
- `bus_miso`  out  1  serial read data, MSB first; 0 when `bus_miso_valid` is low.
- `bus_miso_valid`  out  1  high while `bus_miso` carries a read bit.
- `bus_ready`  out  1  high in IDLE only.
- `bus_done`  out  1  one-cycle pulse in the last cycle of a completed frame.

## Operation
- States: IDLE, ADDR, WDATA, MEM_WR, MEM_RD, RDATA.
- IDLE: `bus_start & bus_sel` → ADDR, latch `bus_rw`, clear bit counter. `bus_start` without `bus_sel` is ignored.
- ADDR: shift `bus_mosi` into the address register for 12 cycles. Then → WDATA (write) or → MEM_RD (read).
- WDATA: shift 8 data bits. Then → MEM_WR.
- MEM_WR: one cycle. Write data to `mem[addr]` at the exiting edge, `bus_done` = 1, then → IDLE.
- MEM_RD: one cycle. Registered memory read, load the shift-out register, then → RDATA.
- RDATA: 8 cycles. `bus_miso_valid` = 1, `bus_miso` = bit 7 down to bit 0. `bus_done` = 1 with bit 0, then → IDLE.
- `bus_start` in any state other than IDLE is ignored.
- Abort: `bus_sel` low in any non-IDLE state → IDLE on the next edge. No memory write, no `bus_done`; an in-flight `bus_miso_valid` drops.
- Reset (any time, including mid-frame): state IDLE, counters and shift registers 0. Memory contents are not reset and are preserved.
- Address is used verbatim; no wrap or offset arithmetic. Unwritten locations read as undefined.

## Timing
- E0 = edge sampling `bus_start`; En = n-th following edge.
- Reset values: `bus_ready` = 1, `bus_done` = 0, `bus_miso` = 0, `bus_miso_valid` = 0.
- Address bits sampled at E1..E12, bit 11 first.
- Write:
  - Data bits sampled at E13..E20, bit 7 first.
  - `bus_done` high during E20–E21; memory written at E21.
- Read:
  - MEM_RD during E12–E13.
  - Bit 7 driven during E13–E14, ..., bit 0 during E20–E21 with `bus_done`.
- Both frame types occupy 21 cycles. `bus_ready` low from E0 to E21 and high again after E21.
- A new frame may start at E21 (back-to-back frames).
- Read-after-write to the same address returns the new data.

## Test plan
- Write 101 to addr 1001, then read addr 1001 → `bus_miso` = 0,1,1,0,0,1,0,1 during E13..E20. `bus_miso_valid` high for exactly those 8 cycles; `bus_done` pulses at E20–E21 on both frames.
- Boundaries: write 0xFF to addr 4095 and 0x00 to addr 0, then read both back → 0xFF and 0x00; neither write corrupts the other location.
- Abort: write 0x55 to addr 5, then start a write of 0xAA to addr 5 and drop `bus_sel` at E15 → no `bus_done`, `bus_ready` returns after the next edge, and a read of addr 5 returns 0x55.
- Start while busy: pulse `bus_start` at E5 of a write frame → ignored; the frame completes at E21 with correct data written.
- Reset mid-read: assert `reset` at E16 of a read → outputs take their reset values immediately. After release `bus_ready` = 1, and re-reading the address returns the stored value.
- Back-to-back: write to addr 7 with the next read of addr 7 started at E21 → the read returns the just-written value and no cycle is lost.

Source files
------------

// File: rtl/bus_slave_port.sv
// bus_slave_port
//   Slave end of the serial shared bus. Deserialises a request frame
//   (rw flag with the start strobe, 12 address bits, 8 write-data bits for
//   writes), accesses a local synchronous memory, and for reads shifts the
//   8-bit word back out MSB first. Every frame is 21 cycles long.
//
// Ports
//   clk            in   clock, rising edge
//   reset          in   asynchronous active-high reset
//   bus_sel        in   decoder select, held high for the whole frame
//   bus_start      in   one-cycle frame-start strobe
//   bus_rw         in   1 = read, 0 = write (sampled with bus_start)
//   bus_mosi       in   serial address/data, MSB first
//   bus_miso       out  serial read data, MSB first (0 when not valid)
//   bus_miso_valid out  high while bus_miso carries a read bit
//   bus_ready      out  high while idle
//   bus_done       out  one-cycle pulse in the last cycle of a frame
module bus_slave_port #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH  = 4096
) (
    input  logic clk,
    input  logic reset,
    input  logic bus_sel,
    input  logic bus_start,
    input  logic bus_rw,
    input  logic bus_mosi,
    output logic bus_miso,
    output logic bus_miso_valid,
    output logic bus_ready,
    output logic bus_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WDATA,
        S_MEM_WR,
        S_MEM_RD,
        S_RDATA
    } state_t;

    localparam int CNT_MAX = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  rw_q, rw_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rsreg_q, rsreg_d;
    logic                  miso_q, miso_d;
    logic                  valid_q, valid_d;
    logic                  ready_q, ready_d;
    logic                  done_q, done_d;

    logic                  start_ok;
    logic                  frame_end;
    logic                  mem_we;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rsreg_d   = rsreg_q;
        frame_end = 1'b0;
        mem_we    = 1'b0;
        start_ok  = bus_start & bus_sel;

        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d = S_ADDR;
                    rw_d    = bus_rw;
                    cnt_d   = '0;
                end
            end
            S_ADDR: begin
                addr_d = {addr_q[ADDR_WIDTH-2:0], bus_mosi};
                if (cnt_q == ADDR_LAST) begin
                    cnt_d   = '0;
                    state_d = rw_q ? S_MEM_RD : S_WDATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WDATA: begin
                wdata_d = {wdata_q[DATA_WIDTH-2:0], bus_mosi};
                if (cnt_q == DATA_LAST) begin
                    cnt_d   = '0;
                    state_d = S_MEM_WR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_MEM_WR: begin
                mem_we    = 1'b1;
                frame_end = 1'b1;
            end
            S_MEM_RD: begin
                rsreg_d = mem[addr_q];
                cnt_d   = '0;
                state_d = S_RDATA;
            end
            S_RDATA: begin
                rsreg_d = {rsreg_q[DATA_WIDTH-2:0], 1'b0};
                if (cnt_q == DATA_LAST) begin
                    frame_end = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The last cycle of a frame doubles as the idle cycle of the next one,
        // so a master can chain frames without losing a cycle.
        if (frame_end) begin
            cnt_d = '0;
            if (start_ok) begin
                state_d = S_ADDR;
                rw_d    = bus_rw;
            end else begin
                state_d = S_IDLE;
            end
        end

        // Losing select aborts the frame: no write, no done, read stream drops.
        if (state_q != S_IDLE && !bus_sel) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            mem_we  = 1'b0;
        end

        // Outputs are registered from the next state so they line up with it.
        ready_d = (state_d == S_IDLE);
        valid_d = (state_d == S_RDATA);
        miso_d  = valid_d ? rsreg_d[DATA_WIDTH-1] : 1'b0;
        done_d  = (state_d == S_MEM_WR) ||
                  ((state_d == S_RDATA) && (cnt_d == DATA_LAST));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rsreg_q <= '0;
            miso_q  <= 1'b0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rsreg_q <= rsreg_d;
            miso_q  <= miso_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    // Memory has no reset so its contents survive a port reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr_q] <= wdata_q;
        end
    end

    assign bus_miso       = miso_q;
    assign bus_miso_valid = valid_q;
    assign bus_ready      = ready_q;
    assign bus_done       = done_q;

endmodule

// File: tb/tb_bus_slave_port.sv
module tb_bus_slave_port;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic bus_sel = 1'b0;
    logic bus_start = 1'b0;
    logic bus_rw = 1'b0;
    logic bus_mosi = 1'b0;
    logic bus_miso;
    logic bus_miso_valid;
    logic bus_ready;
    logic bus_done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Expected {ready, done, valid, miso} for each clock interval.
    logic [3:0] exp_q [$];
    logic [7:0] mem_model [int];
    logic [11:0] written [$];

    bus_slave_port dut (
        .clk           (clk),
        .reset         (reset),
        .bus_sel       (bus_sel),
        .bus_start     (bus_start),
        .bus_rw        (bus_rw),
        .bus_mosi      (bus_mosi),
        .bus_miso      (bus_miso),
        .bus_miso_valid(bus_miso_valid),
        .bus_ready     (bus_ready),
        .bus_done      (bus_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: one expected output word per interval, sampled mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [3:0] e;
            logic [3:0] a;
            e = exp_q.pop_front();
            a = {bus_ready, bus_done, bus_miso_valid, bus_miso};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL outputs cyc %0d: rdy/done/vld/miso got %b expected %b", cyc, a, e);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check_now(input string name, input logic [3:0] exp);
        logic [3:0] a;
        a = {bus_ready, bus_done, bus_miso_valid, bus_miso};
        checks++;
        if (a !== exp) begin
            errors++;
            $display("FAIL %s: rdy/done/vld/miso got %b expected %b", name, a, exp);
        end
    endtask

    task automatic drive(input logic sel, input logic start, input logic rw, input logic mosi);
        bus_sel   = sel;
        bus_start = start;
        bus_rw    = rw;
        bus_mosi  = mosi;
    endtask

    task automatic step(input logic sel, input logic start, input logic rw,
                        input logic mosi, input logic [3:0] exp);
        drive(sel, start, rw, mosi);
        @(posedge clk);
        exp_q.push_back(exp);
        #1;
    endtask

    // Idle cycle. The first one after a frame keeps select high so the
    // frame's exiting edge is not taken as an abort.
    task automatic idle(input bit first);
        logic sel;
        logic start;
        sel   = first ? 1'b1 : 1'($urandom_range(0, 1));
        start = sel ? 1'b0 : 1'($urandom_range(0, 1));
        step(sel, start, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'b1000);
    endtask

    // One frame from E0 to E20; the caller's next step supplies E21.
    task automatic frame(input bit rw, input logic [11:0] addr, input logic [7:0] data,
                         input int abort_at, input int rst_at, input int busy_start_at);
        logic [7:0] rd;
        rd = 8'h00;
        if (rw) rd = mem_model[int'(addr)];
        step(1'b1, 1'b1, rw, 1'($urandom_range(0, 1)), 4'b0000);
        for (int n = 1; n <= 20; n++) begin
            logic mosi;
            logic st;
            logic [3:0] e;
            if (n <= 12)  mosi = addr[12-n];
            else if (!rw) mosi = data[20-n];
            else          mosi = 1'($urandom_range(0, 1));
            st = (n == busy_start_at) ? 1'b1 : 1'($urandom_range(0, 1));
            if (n == abort_at) begin
                step(1'b0, st, 1'($urandom_range(0, 1)), mosi, 4'b1000);
                return;
            end
            if (n == rst_at) begin
                drive(1'b1, st, 1'($urandom_range(0, 1)), mosi);
                @(posedge clk);
                #1;
                reset = 1'b1;
                exp_q.push_back(4'b1000);
                #1;
                check_now("reset_mid_frame", 4'b1000);
                @(posedge clk);
                exp_q.push_back(4'b1000);
                #1;
                reset = 1'b0;
                return;
            end
            if (!rw)     e = (n == 20) ? 4'b0100 : 4'b0000;
            else if (n < 13) e = 4'b0000;
            else         e = {1'b0, (n == 20), 1'b1, rd[20-n]};
            step(1'b1, st, 1'($urandom_range(0, 1)), mosi, e);
        end
        if (!rw) begin
            if (!mem_model.exists(int'(addr))) written.push_back(addr);
            mem_model[int'(addr)] = data;
        end
    endtask

    initial begin
        // Power-on reset
        #1 reset = 1'b1;
        #1 check_now("reset_values", 4'b1000);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        idle(1'b0);

        // Write then read back: 101 = 0110_0101
        frame(1'b0, 12'd1001, 8'd101, 0, 0, 0);
        idle(1'b1);
        frame(1'b1, 12'd1001, 8'h00, 0, 0, 0);
        idle(1'b1);

        // Address boundaries
        frame(1'b0, 12'd4095, 8'hFF, 0, 0, 0);
        idle(1'b1);
        frame(1'b0, 12'd0, 8'h00, 0, 0, 0);
        idle(1'b1);
        frame(1'b1, 12'd4095, 8'h00, 0, 0, 0);
        idle(1'b1);
        frame(1'b1, 12'd0, 8'h00, 0, 0, 0);
        idle(1'b1);

        // Abort during write data leaves old contents
        frame(1'b0, 12'd5, 8'h55, 0, 0, 0);
        idle(1'b1);
        frame(1'b0, 12'd5, 8'hAA, 15, 0, 0);
        idle(1'b1);
        idle(1'b0);
        frame(1'b1, 12'd5, 8'h00, 0, 0, 0);
        idle(1'b1);

        // Start strobe while busy is ignored
        frame(1'b0, 12'd300, 8'hC3, 0, 0, 5);
        idle(1'b1);
        frame(1'b1, 12'd300, 8'h00, 0, 0, 0);
        idle(1'b1);

        // Reset in the middle of a read; memory survives
        frame(1'b0, 12'd9, 8'h3C, 0, 0, 0);
        idle(1'b1);
        frame(1'b1, 12'd9, 8'h00, 0, 16, 0);
        idle(1'b1);
        frame(1'b1, 12'd9, 8'h00, 0, 0, 0);
        idle(1'b1);

        // Back-to-back write then read of the same address
        frame(1'b0, 12'd7, 8'h9A, 0, 0, 0);
        frame(1'b1, 12'd7, 8'h00, 0, 0, 0);
        idle(1'b1);

        // Randomized traffic
        for (int i = 0; i < 60; i++) begin
            int r;
            int ab;
            logic [11:0] a;
            r  = int'($urandom_range(0, 9));
            ab = (r == 9) ? int'($urandom_range(1, 20)) : 0;
            if (written.size() == 0 || r < 5) begin
                a = (r < 2) ? 12'($urandom_range(0, 15)) : 12'($urandom);
                frame(1'b0, a, 8'($urandom), ab, 0, 0);
            end else begin
                a = written[$urandom_range(0, written.size() - 1)];
                frame(1'b1, a, 8'h00, ab, 0, 0);
            end
            if ($urandom_range(0, 1) == 0) begin
                int g;
                g = int'($urandom_range(1, 3));
                for (int k = 0; k < g; k++) idle(k == 0);
            end
        end
        idle(1'b1);
        idle(1'b0);
        idle(1'b0);

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
